// File: rtl/modbus_rtu_pkg.sv
// Shared Modbus RTU definitions: function codes, CRC-16/MODBUS constants, receiver states.
// Also holds the one-byte reflected CRC update used by the CRC sub-module.
package modbus_rtu_pkg;

    localparam logic [7:0]  FC_READ  = 8'h03;
    localparam logic [7:0]  FC_WRITE = 8'h10;
    localparam logic [7:0]  EXC_MASK = 8'h80;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam logic [15:0] CRC_POLY = 16'hA001;

    typedef enum logic [3:0] {
        IDLE,
        FUNC,
        W_ADR_HI,
        W_ADR_LO,
        W_QTY_HI,
        W_QTY_LO,
        R_BCNT,
        R_DATA_HI,
        R_DATA_LO,
        EXC,
        CRC_LO,
        CRC_HI,
        SKIP
    } rx_state_t;

    function automatic logic [15:0] crc16_update(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/modbus_crc16_byte.sv
// Combinational CRC-16/MODBUS update by one byte; zero latency, no flow control.
module modbus_crc16_byte
    import modbus_rtu_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data_byte,
    output logic [15:0] crc_out
);

    assign crc_out = crc16_update(crc_in, data_byte);

endmodule

// File: rtl/modbus_rtu_rx_control.sv
// Modbus RTU response receiver; all outputs registered one cycle after the triggering byte.
// No backpressure (byte_valid is a strobe); MODBUS_RX_CRC_CHECK_EN enables CRC verification.
module modbus_rtu_rx_control
    import modbus_rtu_pkg::*;
#(
    parameter int clk_freq_MHz = 80,
    parameter int gap_us       = 2000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  adr,
    input  logic        expect_read,
    input  logic [15:0] adr_first_reg_tx,
    input  logic [7:0]  num_reg_tx,
    input  logic [7:0]  num_reg_rx,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic [15:0] data_out,
    output logic [7:0]  data_addr,
    output logic        data_we,
    output logic        answer_received,
    output logic        frame_ok,
    output logic        crc_err,
    output logic        frame_err,
    output logic [7:0]  exception_code
);

    localparam logic [23:0] GAP_PERIOD = 24'(gap_us * clk_freq_MHz);

    rx_state_t   state;
    rx_state_t   cur_state;
    logic [23:0] gap_cnt;
    logic        timeout;
    logic        exp_rd;
    logic        foreign;
    logic        err_q;
    logic        is_exc;
    logic [7:0]  reg_idx;
    logic [7:0]  data_hi;
    logic [7:0]  func_exp;
    logic        crc_bad;

    assign timeout   = (state != IDLE) && (gap_cnt == GAP_PERIOD);
    // A byte arriving in the expiry cycle starts a new frame.
    assign cur_state = timeout ? IDLE : state;
    assign func_exp  = exp_rd ? FC_READ : FC_WRITE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gap_cnt <= '0;
        end else if (byte_valid || state == IDLE || timeout) begin
            gap_cnt <= '0;
        end else if (gap_cnt != GAP_PERIOD) begin
            gap_cnt <= gap_cnt + 24'd1;
        end
    end

`ifdef MODBUS_RX_CRC_CHECK_EN
    logic [15:0] crc_q;
    logic [15:0] crc_base;
    logic [15:0] crc_next;
    logic [7:0]  crc_lo;

    assign crc_base = (cur_state == IDLE) ? CRC_INIT : crc_q;

    modbus_crc16_byte u_crc (
        .crc_in    (crc_base),
        .data_byte (byte_in),
        .crc_out   (crc_next)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_q  <= CRC_INIT;
            crc_lo <= '0;
        end else if (byte_valid) begin
            if (cur_state == CRC_LO) begin
                crc_lo <= byte_in;
            end else if (cur_state != CRC_HI && cur_state != SKIP) begin
                crc_q <= crc_next;
            end
        end
    end

    assign crc_bad = ({byte_in, crc_lo} != crc_q);
`else
    assign crc_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            exp_rd          <= 1'b0;
            foreign         <= 1'b0;
            err_q           <= 1'b0;
            is_exc          <= 1'b0;
            reg_idx         <= '0;
            data_hi         <= '0;
            data_out        <= '0;
            data_addr       <= '0;
            data_we         <= 1'b0;
            answer_received <= 1'b0;
            frame_ok        <= 1'b0;
            crc_err         <= 1'b0;
            frame_err       <= 1'b0;
            exception_code  <= '0;
        end else begin
            data_we         <= 1'b0;
            answer_received <= 1'b0;
            if (timeout) state <= IDLE;

            if (byte_valid) begin
                case (cur_state)
                    IDLE: begin
                        if (byte_in == adr) begin
                            state          <= FUNC;
                            exp_rd         <= expect_read;
                            foreign        <= 1'b0;
                            err_q          <= 1'b0;
                            is_exc         <= 1'b0;
                            reg_idx        <= '0;
                            frame_ok       <= 1'b0;
                            crc_err        <= 1'b0;
                            frame_err      <= 1'b0;
                            exception_code <= '0;
                        end else begin
                            state   <= SKIP;
                            foreign <= 1'b1;
                        end
                    end
                    FUNC: begin
                        if (byte_in == func_exp) begin
                            state <= exp_rd ? R_BCNT : W_ADR_HI;
                        end else if (byte_in == (func_exp | EXC_MASK)) begin
                            state <= EXC;
                        end else begin
                            state <= SKIP;
                            err_q <= 1'b1;
                        end
                    end
                    W_ADR_HI: begin
                        if (byte_in != adr_first_reg_tx[15:8]) err_q <= 1'b1;
                        state <= W_ADR_LO;
                    end
                    W_ADR_LO: begin
                        if (byte_in != adr_first_reg_tx[7:0]) err_q <= 1'b1;
                        state <= W_QTY_HI;
                    end
                    W_QTY_HI: begin
                        if (byte_in != 8'h00) err_q <= 1'b1;
                        state <= W_QTY_LO;
                    end
                    W_QTY_LO: begin
                        if (byte_in != num_reg_tx) err_q <= 1'b1;
                        state <= CRC_LO;
                    end
                    R_BCNT: begin
                        if (byte_in != {num_reg_rx[6:0], 1'b0}) begin
                            state <= SKIP;
                            err_q <= 1'b1;
                        end else if (num_reg_rx == 8'd0) begin
                            state <= CRC_LO;
                        end else begin
                            state <= R_DATA_HI;
                        end
                    end
                    R_DATA_HI: begin
                        data_hi <= byte_in;
                        state   <= R_DATA_LO;
                    end
                    R_DATA_LO: begin
                        data_out  <= {data_hi, byte_in};
                        data_addr <= reg_idx;
                        data_we   <= 1'b1;
                        reg_idx   <= reg_idx + 8'd1;
                        state     <= (reg_idx == num_reg_rx - 8'd1) ? CRC_LO : R_DATA_HI;
                    end
                    EXC: begin
                        exception_code <= byte_in;
                        is_exc         <= 1'b1;
                        state          <= CRC_LO;
                    end
                    CRC_LO: begin
                        state <= CRC_HI;
                    end
                    CRC_HI: begin
                        answer_received <= 1'b1;
                        crc_err         <= crc_bad;
                        frame_err       <= err_q;
                        frame_ok        <= !crc_bad && !err_q && !is_exc;
                        state           <= IDLE;
                    end
                    SKIP: begin
                        state <= SKIP;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end

            // Placed last so a timeout report wins over a same-cycle address byte.
            if (timeout && !(state == SKIP && foreign)) begin
                answer_received <= 1'b1;
                frame_err       <= 1'b1;
                frame_ok        <= 1'b0;
                crc_err         <= 1'b0;
            end
        end
    end

endmodule
